// File: rtl/tau_route_pkg.sv
// Shared definitions for the ALU operand router: special side-B select codes
// and a one-hot decoder used by the operand pickers and the writeback steer.
package tau_route_pkg;

  // Side-B codes above the register range: NUM_REGS + SEL_B_IMM_OFS selects imm.
  localparam int SEL_B_IMM_OFS = 0;

  // Widest one-hot vector the decoder can produce; callers size-cast the result.
  localparam int ONEHOT_MAX_W = 64;

  // One-hot decode of idx into n valid positions; an index >= n gives all zeros.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot_dec(input int idx, input int n);
    logic [ONEHOT_MAX_W-1:0] vec;
    vec = '0;
    for (int k = 0; k < ONEHOT_MAX_W; k++) begin
      vec[k] = (k < n) && (k == idx);
    end
    return vec;
  endfunction

endpackage

// File: rtl/operand_pick.sv
// Combinational select-plus-forward for one ALU operand side. Codes below
// NUM_REGS pick a register (replaced by the in-flight write when it targets
// that register), code NUM_REGS picks imm, anything else yields zero.
module operand_pick
  import tau_route_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 8,
  parameter int SEL_W     = 4
) (
  input  logic [NUM_REGS*WORD_SIZE-1:0] reg_file_in,
  input  logic [SEL_W-1:0]              sel,
  input  logic [WORD_SIZE-1:0]          imm,
  input  logic [NUM_REGS-1:0]           fwd_en,
  input  logic [WORD_SIZE-1:0]          fwd_data,
  output logic [WORD_SIZE-1:0]          operand
);

  logic [NUM_REGS-1:0]  hit_s;
  logic [WORD_SIZE-1:0] reg_val_s;

  // Register path: one-hot hit mask, each entry swapped for fwd_data if being written.
  always_comb begin
    hit_s     = NUM_REGS'(onehot_dec(int'(sel), NUM_REGS));
    reg_val_s = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_val_s = reg_val_s |
                  ({WORD_SIZE{hit_s[k]}} &
                   (fwd_en[k] ? fwd_data : reg_file_in[k*WORD_SIZE +: WORD_SIZE]));
    end
  end

  // Final operand mux across register, immediate and zero codes.
  always_comb begin
    operand = '0;
    if (int'(sel) < NUM_REGS) begin
      operand = reg_val_s;
    end else if (int'(sel) == NUM_REGS + SEL_B_IMM_OFS) begin
      operand = imm;
    end else begin
      operand = '0;
    end
  end

endmodule

// File: rtl/alu_operand_router.sv
// Operand-select and writeback-steer stage between register file and ALU.
// Operands leave through a valid/ready output register; ALU results return
// as a registered one-hot write that is also forwarded to the pickers.
module alu_operand_router
  import tau_route_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 8,
  localparam int SEL_A_W   = $clog2(NUM_REGS),
  localparam int SEL_B_W   = $clog2(NUM_REGS + 2)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REGS*WORD_SIZE-1:0] reg_file_in,
  input  logic [WORD_SIZE-1:0]          imm,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [SEL_A_W-1:0]            sel_a,
  input  logic [SEL_B_W-1:0]            sel_b,
  output logic [WORD_SIZE-1:0]          operand_a,
  output logic [WORD_SIZE-1:0]          operand_b,
  output logic                          opnd_valid,
  input  logic                          opnd_ready,
  input  logic                          wb_valid,
  input  logic [SEL_A_W-1:0]            wb_dest,
  input  logic [WORD_SIZE-1:0]          wb_data,
  output logic [NUM_REGS-1:0]           wr_en,
  output logic [WORD_SIZE-1:0]          wr_data,
  output logic                          bad_sel
);

  logic                 accept_s;
  logic                 sel_b_bad_s;
  logic [WORD_SIZE-1:0] pick_a_s;
  logic [WORD_SIZE-1:0] pick_b_s;

  // Ready whenever the output slot is empty or drains this cycle; never in reset.
  assign op_ready    = !rst && (!opnd_valid || opnd_ready);
  assign accept_s    = op_valid && op_ready;
  assign sel_b_bad_s = int'(sel_b) > NUM_REGS;

  // Side A has no immediate: its imm input is tied to zero.
  operand_pick #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS),
    .SEL_W     (SEL_A_W)
  ) u_pick_a (
    .reg_file_in (reg_file_in),
    .sel         (sel_a),
    .imm         ({WORD_SIZE{1'b0}}),
    .fwd_en      (wr_en),
    .fwd_data    (wr_data),
    .operand     (pick_a_s)
  );

  operand_pick #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS),
    .SEL_W     (SEL_B_W)
  ) u_pick_b (
    .reg_file_in (reg_file_in),
    .sel         (sel_b),
    .imm         (imm),
    .fwd_en      (wr_en),
    .fwd_data    (wr_data),
    .operand     (pick_b_s)
  );

  // Operand output register: load on accept, drain when consumed, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_a  <= '0;
      operand_b  <= '0;
      opnd_valid <= 1'b0;
    end else if (accept_s) begin
      operand_a  <= pick_a_s;
      operand_b  <= pick_b_s;
      opnd_valid <= 1'b1;
    end else if (opnd_ready) begin
      opnd_valid <= 1'b0;
    end
  end

  // Writeback steer: one-cycle one-hot write enable plus data, dropped in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= '0;
      wr_data <= '0;
    end else begin
      if (wb_valid) begin
        wr_en <= NUM_REGS'(onehot_dec(int'(wb_dest), NUM_REGS));
      end else begin
        wr_en <= '0;
      end
      wr_data <= wb_data;
    end
  end

  // Sticky flag for accepted requests whose side-B code is past the immediate.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_sel <= 1'b0;
    end else if (accept_s && sel_b_bad_s) begin
      bad_sel <= 1'b1;
    end
  end

endmodule
